cache_bus_rr_arbiter: RTL and testbench

- Round-robin scheduler that shares the single cache-line transfer engine (the AXI load/store line mover) among CONNECTIONS cache requesters.
- Accepts one line command at a time and issues it to the engine with a valid/ready handshake.
- Waits for engine completion, then returns a one-hot completion to the owning cache.
- Replaces fixed lowest-index selection so that an I-cache cannot be starved by a D-cache.

---
 rtl/cache_bus_rr_arbiter.sv | 136 +++++++++++++
 tb/tb_cache_bus_rr_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cache_bus_rr_arbiter
//
// Round-robin scheduler that shares one cache-line transfer engine among
// CONNECTIONS cache requesters. One line command is in flight at a time:
// it is granted in IDLE, offered to the engine in ISSUE, tracked in WAIT
// until the engine finishes, and the completion is returned to the owning
// cache in RESP.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   req_valid       per-cache command request
//   req_store       per-cache store flag (1 = writeback, 0 = fill)
//   req_addr        per-cache line address, packed [CONNECTIONS-1:0][ADDR_WIDTH-1:0]
//   req_accept      one-hot, 1-cycle pulse: command taken
//   hold            snoop/invalidate in progress; blocks new grants in IDLE
//   eng_valid       command valid to engine
//   eng_store       forwarded store flag
//   eng_addr        forwarded line address
//   eng_id          index of the owning cache
//   eng_ready       engine accepts command
//   eng_done        1-cycle pulse: transfer finished
//   resp_valid      one-hot completion to owner
//   resp_ready      per-cache completion consume
//   busy            high whenever not IDLE
//   owner           current/last grantee
// ---------------------------------------------------------------------------
module cache_bus_rr_arbiter #(
    parameter int ADDR_WIDTH  = 64,
    parameter int CONNECTIONS = 2,
    parameter int ID_W        = $clog2(CONNECTIONS)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [CONNECTIONS-1:0]                req_valid,
    input  logic [CONNECTIONS-1:0]                req_store,
    input  logic [CONNECTIONS-1:0][ADDR_WIDTH-1:0] req_addr,
    output logic [CONNECTIONS-1:0]                req_accept,
    input  logic                                  hold,
    output logic                                  eng_valid,
    output logic                                  eng_store,
    output logic [ADDR_WIDTH-1:0]                 eng_addr,
    output logic [ID_W-1:0]                       eng_id,
    input  logic                                  eng_ready,
    input  logic                                  eng_done,
    output logic [CONNECTIONS-1:0]                resp_valid,
    input  logic [CONNECTIONS-1:0]                resp_ready,
    output logic                                  busy,
    output logic [ID_W-1:0]                       owner
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [CONNECTIONS-1:0] ONE_HOT_0 = {{(CONNECTIONS-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0]        LAST_ID   = ID_W'(CONNECTIONS - 1);

    state_t                state, state_next;
    logic [ID_W-1:0]       rr_ptr;
    logic                  cmd_store;
    logic [ADDR_WIDTH-1:0] cmd_addr;

    logic                  grant_found;
    logic [ID_W-1:0]       grant_id;
    logic [ID_W-1:0]       scan_id;
    logic                  take;

    // Rotating priority search: the first requester at or after rr_ptr
    // (modulo CONNECTIONS) wins.
    // NOTE: every signal assigned in an always_comb gets a default at the
    // top of the block, otherwise a path that skips the assignment infers a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_id     = '0;
        for (int i = 0; i < CONNECTIONS; i++) begin
            scan_id = ID_W'((int'(rr_ptr) + i) % CONNECTIONS);
            if (!grant_found && req_valid[scan_id]) begin
                grant_found = 1'b1;
                grant_id    = scan_id;
            end
        end
    end

    // hold only gates the grant decision; an in-flight transfer runs to completion.
    assign take = (state == ST_IDLE) && !hold && grant_found;

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (take)              state_next = ST_ISSUE;
            ST_ISSUE: if (eng_ready)         state_next = ST_WAIT;
            // eng_ready is meaningless here; only completion advances.
            ST_WAIT:  if (eng_done)          state_next = ST_RESP;
            ST_RESP:  if (resp_ready[owner]) state_next = ST_IDLE;
            default:                         state_next = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            cmd_store  <= 1'b0;
            cmd_addr   <= '0;
            req_accept <= '0;
        end else begin
            state      <= state_next;
            req_accept <= '0;
            if (take) begin
                cmd_store  <= req_store[grant_id];
                cmd_addr   <= req_addr[grant_id];
                owner      <= grant_id;
                req_accept <= ONE_HOT_0 << grant_id;
                rr_ptr     <= (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
            end
        end
    end

    // The command registers only load on a grant, so the engine-side fields
    // are stable for the whole ISSUE phase by construction.
    assign eng_valid  = (state == ST_ISSUE);
    assign eng_store  = cmd_store;
    assign eng_addr   = cmd_addr;
    assign eng_id     = owner;
    assign resp_valid = (state == ST_RESP) ? (ONE_HOT_0 << owner) : '0;
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_cache_bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_bus_rr_arbiter
//
// Directed bench for cache_bus_rr_arbiter with two requesters. Inputs are
// driven 1 time unit after each rising edge; outputs are checked at the same
// point, so each check sees the state produced by the preceding edge.
// ---------------------------------------------------------------------------
module tb_cache_bus_rr_arbiter;

    localparam int ADDR_WIDTH  = 64;
    localparam int CONNECTIONS = 2;
    localparam int ID_W        = $clog2(CONNECTIONS);

    logic                                   clk = 1'b0;
    logic                                   reset;
    logic [CONNECTIONS-1:0]                 req_valid;
    logic [CONNECTIONS-1:0]                 req_store;
    logic [CONNECTIONS-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [CONNECTIONS-1:0]                 req_accept;
    logic                                   hold;
    logic                                   eng_valid;
    logic                                   eng_store;
    logic [ADDR_WIDTH-1:0]                  eng_addr;
    logic [ID_W-1:0]                        eng_id;
    logic                                   eng_ready;
    logic                                   eng_done;
    logic [CONNECTIONS-1:0]                 resp_valid;
    logic [CONNECTIONS-1:0]                 resp_ready;
    logic                                   busy;
    logic [ID_W-1:0]                        owner;

    int tests  = 0;
    int failed = 0;

    cache_bus_rr_arbiter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CONNECTIONS(CONNECTIONS),
        .ID_W       (ID_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_store (req_store),
        .req_addr  (req_addr),
        .req_accept(req_accept),
        .hold      (hold),
        .eng_valid (eng_valid),
        .eng_store (eng_store),
        .eng_addr  (eng_addr),
        .eng_id    (eng_id),
        .eng_ready (eng_ready),
        .eng_done  (eng_done),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .busy      (busy),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive an already-issued command through WAIT and RESP back to IDLE.
    task automatic complete(input logic [1:0] who);
        eng_ready = 1'b1;
        tick();
        eng_ready = 1'b0;
        check("wait_eng_valid", eng_valid, 0);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("resp_valid", resp_valid, who);
        resp_ready = who;
        tick();
        resp_ready = '0;
        check("resp_exit_busy", busy, 0);
    endtask

    // Engine contract: completion may not coincide with an accepted issue.
    always @(negedge clk) begin
        if (!reset && eng_valid && eng_ready && eng_done) begin
            failed++;
            $error("FAIL engine_contract: eng_done with eng_valid&eng_ready observed 1 required 0");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, observed running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 2'b11;
        req_store  = '0;
        req_addr   = '0;
        hold       = 1'b0;
        eng_ready  = 1'b0;
        eng_done   = 1'b0;
        resp_ready = '0;

        // ---------------- reset state (requests asserted during reset) --------
        tick();
        tick();
        check("rst_req_accept", req_accept, 0);
        check("rst_eng_valid",  eng_valid,  0);
        check("rst_busy",       busy,       0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_owner",      owner,      0);
        check("rst_eng_addr",   eng_addr,   0);
        req_valid = '0;
        reset     = 1'b0;
        tick();
        check("post_rst_busy", busy, 0);

        // ---------------- single load from cache 0 ----------------
        req_valid   = 2'b01;
        req_addr[0] = 64'h1000;
        req_store   = 2'b00;
        tick();
        check("load_accept",    req_accept, 2'b01);
        check("load_eng_valid", eng_valid,  1);
        check("load_eng_addr",  eng_addr,   64'h1000);
        check("load_eng_store", eng_store,  0);
        check("load_eng_id",    eng_id,     0);
        check("load_busy",      busy,       1);
        req_valid = '0;
        tick();
        check("load_accept_pulse", req_accept, 0);
        check("load_issue_hold",   eng_valid,  1);
        complete(2'b01);

        // ---------------- hold blocks grant (rr_ptr now 1) ----------------
        hold        = 1'b1;
        req_valid   = 2'b10;
        req_addr[1] = 64'hBEEF_0040;
        req_store   = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_no_accept", req_accept, 0);
            check("hold_idle",      busy,       0);
        end
        hold = 1'b0;
        tick();
        check("hold_release_accept", req_accept, 2'b10);
        check("hold_eng_id",         eng_id,     1);
        check("hold_eng_store",      eng_store,  1);
        check("hold_eng_addr",       eng_addr,   64'hBEEF_0040);
        req_valid = '0;
        // hold raised mid-transaction must not abort it
        hold = 1'b1;
        complete(2'b10);
        hold = 1'b0;

        // ---------------- contention: grants alternate 0,1,0,1 ----------------
        req_valid   = 2'b11;
        req_addr[0] = 64'h2000;
        req_addr[1] = 64'h3000;
        req_store   = 2'b10;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_accept",    req_accept, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("rr_eng_id",    eng_id,     k % 2);
            check("rr_eng_addr",  eng_addr,   (k % 2 == 0) ? 64'h2000 : 64'h3000);
            check("rr_eng_store", eng_store,  k % 2);
            complete((k % 2 == 0) ? 2'b01 : 2'b10);
        end
        req_valid = '0;

        // ---------------- backpressure: command stable for 6 cycles ----------------
        req_valid   = 2'b01;
        req_addr[0] = 64'h4440;
        req_store   = 2'b01;
        tick();
        check("bp_accept", req_accept, 2'b01);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_eng_valid",  eng_valid,  1);
            check("bp_eng_addr",   eng_addr,   64'h4440);
            check("bp_eng_store",  eng_store,  1);
            check("bp_eng_id",     eng_id,     0);
            check("bp_no_reaccept", req_accept, 0);
        end
        req_valid = '0;
        complete(2'b01);

        // ---------------- response stall (rr_ptr=1, only cache 0 asks) ----------------
        req_valid   = 2'b01;
        req_addr[0] = 64'h5000;
        req_store   = 2'b00;
        tick();
        check("stall_accept", req_accept, 2'b01);
        check("stall_owner",  owner,      0);
        req_valid = '0;
        eng_ready = 1'b1;
        tick();
        // ready and done together in WAIT: done is what counts
        eng_done = 1'b1;
        tick();
        eng_ready = 1'b0;
        eng_done  = 1'b0;
        check("stall_enter_resp", resp_valid, 2'b01);
        resp_ready = 2'b10;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_resp_valid", resp_valid, 2'b01);
            check("stall_busy",       busy,       1);
        end
        resp_ready = 2'b01;
        tick();
        resp_ready = '0;
        check("stall_exit_busy", busy,       0);
        check("stall_exit_resp", resp_valid, 0);

        // ---------------- async reset in WAIT (rr_ptr=1 before reset) ----------------
        req_valid   = 2'b01;
        req_addr[0] = 64'h6000;
        tick();
        check("arst_accept", req_accept, 2'b01);
        req_valid = '0;
        eng_ready = 1'b1;
        tick();
        eng_ready = 1'b0;
        check("arst_in_wait", busy, 1);
        #3;
        reset = 1'b1;
        #1;
        check("arst_busy",       busy,       0);
        check("arst_eng_valid",  eng_valid,  0);
        check("arst_resp_valid", resp_valid, 0);
        check("arst_eng_addr",   eng_addr,   0);
        check("arst_owner",      owner,      0);
        eng_done = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        eng_done = 1'b0;
        check("arst_done_ignored", resp_valid, 0);
        check("arst_idle",         busy,       0);
        req_valid = 2'b11;
        tick();
        req_valid = '0;
        check("arst_ptr_reset_accept", req_accept, 2'b01);
        check("arst_ptr_reset_id",     eng_id,     0);
        complete(2'b01);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
